// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver.
// Digit/control inputs from the BCD stage, multiplexed SEG/AN/FRAME outputs.
interface sevenseg_scan_driver_if;
    logic       LOAD;
    logic [3:0] ONES;
    logic [3:0] TENS;
    logic [1:0] HUNDREDS;
    logic       LZ_BLANK;
    logic       BLINK;
    logic [6:0] SEG;
    logic [2:0] AN;
    logic       FRAME;

    modport master (
        output LOAD, ONES, TENS, HUNDREDS, LZ_BLANK, BLINK,
        input  SEG, AN, FRAME
    );

    modport slave (
        input  LOAD, ONES, TENS, HUNDREDS, LZ_BLANK, BLINK,
        output SEG, AN, FRAME
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 3-digit seven-segment driver with frame-synchronous
// shadow load, leading-zero blanking and blink.
// Ports: CLK, RST_N (sync, active-low), bus (slave): LOAD, ONES, TENS,
// HUNDREDS, LZ_BLANK, BLINK in; SEG {g..a}, AN {h,t,o}, FRAME out.
module sevenseg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input logic                  CLK,
    input logic                  RST_N,
    sevenseg_scan_driver_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BF_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] OFF_SEG  = {7{ACTIVE_LOW}};
    localparam logic [2:0] OFF_AN   = {3{ACTIVE_LOW}};

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic [9:0]    shadow;
    logic [9:0]    disp;
    logic          pending;
    logic [BW-1:0] blink_cnt;
    logic          blink_hidden;
    logic          frame_start;

    logic          tick;
    logic          frame_end;
    logic [9:0]    load_data;

    assign tick      = (prescaler == PS_LAST);
    assign frame_end = tick && (idx == DIG_HUND);
    assign load_data = {bus.HUNDREDS, bus.TENS, bus.ONES};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prescaler    <= '0;
            idx          <= DIG_ONES;
            shadow       <= '0;
            disp         <= '0;
            pending      <= 1'b0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            prescaler   <= tick ? '0 : prescaler + 1'b1;
            frame_start <= frame_end;

            if (tick) begin
                idx <= (idx == DIG_HUND) ? DIG_ONES : idx + 2'd1;
            end

            if (bus.LOAD) begin
                shadow <= load_data;
            end

            // A LOAD landing on the frame-end cycle goes straight to
            // the display so it is not held back a whole frame.
            if (frame_end) begin
                if (bus.LOAD) begin
                    disp <= load_data;
                end else if (pending) begin
                    disp <= shadow;
                end
                pending <= 1'b0;
            end else if (bus.LOAD) begin
                pending <= 1'b1;
            end

            if (frame_end) begin
                if (blink_cnt == BF_LAST) begin
                    blink_cnt    <= '0;
                    blink_hidden <= ~blink_hidden;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_dec;
    logic [6:0] seg_nxt;
    logic [2:0] an_nxt;

    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        unique case (1'b1)
            idx == DIG_ONES: begin
                digit = disp[3:0];
                blank = 1'b0;
            end
            idx == DIG_TENS: begin
                digit = disp[7:4];
                blank = bus.LZ_BLANK && (disp[9:4] == 6'd0);
            end
            idx == DIG_HUND: begin
                // Hundreds value 3 is out of range: map to a dash code.
                digit = (disp[9:8] == 2'd3) ? 4'hA : {2'b00, disp[9:8]};
                blank = bus.LZ_BLANK && (disp[9:8] == 2'd0);
            end
            default: ;
        endcase

        if (bus.BLINK && blink_hidden) begin
            blank = 1'b1;
        end

        case (digit)
            4'd0:    seg_dec = 7'h3F;
            4'd1:    seg_dec = 7'h06;
            4'd2:    seg_dec = 7'h5B;
            4'd3:    seg_dec = 7'h4F;
            4'd4:    seg_dec = 7'h66;
            4'd5:    seg_dec = 7'h6D;
            4'd6:    seg_dec = 7'h7D;
            4'd7:    seg_dec = 7'h07;
            4'd8:    seg_dec = 7'h7F;
            4'd9:    seg_dec = 7'h6F;
            default: seg_dec = SEG_DASH;
        endcase

        seg_nxt = blank ? 7'h00 : seg_dec;
        an_nxt  = blank ? 3'b000 : (3'b001 << idx);
    end

    // FRAME is the frame-end strobe delayed twice so it lines up with
    // the registered outputs showing digit 0 of the new frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.SEG   <= OFF_SEG;
            bus.AN    <= OFF_AN;
            bus.FRAME <= 1'b0;
        end else begin
            bus.SEG   <= seg_nxt ^ OFF_SEG;
            bus.AN    <= an_nxt ^ OFF_AN;
            bus.FRAME <= frame_start;
        end
    end
endmodule
